lif_neuron_multi_dualleak_system: RTL and testbench
===================================================

// Module: lif_neuron_multi_dualleak_system
// PURPOSE
//  NUM_CH-input leaky integrate-and-fire neuron with two leak regimes and a refractory period.
//  Parameters arrive over a serial configuration port into a shadow shift register.
//  A complete frame commits atomically, so the neuron keeps running on the old parameter set during a reload.
//  Top-level neuron tile for the spiking datapath. Generalises the single-channel dual-leak neuron system.
// PARAMETERS
//  NUM_CH   4  input channel count (>=1)
//  IN_W     6  bits per input channel
//  W_W      3  bits per channel weight (unsigned)
//  VMEM_W   8  membrane potential / threshold / leak-rate width
//  LCYC_W   4  leak-period field width
//  REF_W    4  refractory-length field width
// PORTS
//  clk           in   1                 system clock, rising edge
//  reset         in   1                 asynchronous, active-low; all state cleared while 0
//  enable        in   1                 global clock enable; 0 freezes every register (loader included)
//  input_enable  in   1                 1: integrate inputs this cycle; 0: leak only
//  chan_in       in   NUM_CH*IN_W       channel i at [i*IN_W +: IN_W]
//  load_mode     in   1                 1: shift serial_data into shadow register
//  serial_data   in   1                 config bit, MSB-first
//  spike_out     out  1                 one-cycle spike pulse
//  v_mem_out     out  VMEM_W            current membrane potential
//  params_ready  out  1                 a valid parameter set is active
//  frame_error   out  1                 sticky: last frame had wrong bit count
// BEHAVIOUR
//  Reset: all outputs 0; v_mem=0; refractory and leak counters 0; active parameters all 0; shadow register and bit counter 0.
//  Frame: FRAME_W = NUM_CH*W_W + 3*VMEM_W + 2*LCYC_W + REF_W (default 48).
//   Field order, first bit shifted in first:
//   weight[NUM_CH-1..0], leak_rate_1, leak_rate_2, threshold, leak_cycles_1, leak_cycles_2, refrac.
//  Loader (enable=1 only):
//   - Each load_mode=1 cycle shifts serial_data into the shadow LSB. The bit counter saturates at FRAME_W+1.
//   - load_mode 1->0 edge, counter==FRAME_W: copy shadow to active set; params_ready<=1; frame_error<=0.
//   - load_mode 1->0 edge, counter!=FRAME_W: discard the shadow; frame_error<=1; active set and params_ready unchanged.
//   - Bit counter clears on the 1->0 edge.
//   - New values take effect on the cycle after the commit edge.
//  Neuron updates only when enable=1 and params_ready=1; otherwise v_mem, counters and spike_out hold at 0 or current values.
//  Sum: S = sum(chan_i*weight_i) when input_enable=1, else 0. Width IN_W+W_W+clog2(NUM_CH), no overflow.
//  Leak regime: fast (leak_rate_1, period leak_cycles_1) when v_mem >= threshold>>1; slow (leak_rate_2, leak_cycles_2) otherwise.
//   Period 0 is treated as 1.
//  Leak counter:
//   - Increments every neuron-update cycle.
//   - When it reaches period-1, leak L = rate applies this cycle and the counter wraps to 0.
//   - Otherwise L=0. The counter resets to 0 on a regime change.
//  v_next = clamp(v_mem + S - L, 0, 2^VMEM_W-1); saturates at both ends, never wraps.
//  Fire: if threshold != 0 and v_next >= threshold:
//   spike_out<=1 and v_mem<=0 on the same edge; ref_cnt<=refrac.
//   Latency is 1 cycle from the inputs to spike_out.
//  Refractory (ref_cnt != 0): S is forced to 0, no leak, v_mem held at 0, spike_out=0, ref_cnt decrements.
//  threshold=0: the neuron never fires and integrates with saturation.
//  spike_out is high for exactly one cycle per fire. With refrac=0, back-to-back fires on consecutive cycles are legal.
//  Reset mid-load: the partial frame is lost and params_ready returns to 0.
// STRUCTURE
//  Package lif_neuron_pkg: FRAME_W function, field offset localparams, clamp helper function.
//  Sub-module lif_param_loader: shadow shift register, bit counter, commit/error logic; drives the active parameter bus.
//  Neuron datapath (MAC, leak select, refractory FSM IDLE/REFRAC) inline in this module.
// TESTING
//  1. Frame: weights=1, thr=20, rates=0, refrac=2; chan=5 on all 4 channels, input_enable=1.
//     -> v_mem stays 0. spike at cycles 1, 4, 7, 10 after params_ready.
//  2. Weights=1, thr=200, ch0=10 (others 0), leak_rate_2=3, leak_cycles_2=4.
//     -> v_mem increments by 10 per cycle, less 3 every 4th cycle. Fast regime applies once v_mem>=100.
//  3. Input 0, v_mem=5, leak_rate_2=8, leak_cycles_2=1 -> v_mem=0 next cycle (floor clamp, no wrap).
//  4. Weights=7, chan=63 x4, thr=0 -> v_mem saturates at 255; no spike.
//  5. 47-bit frame -> frame_error=1, old parameters still active.
//     A following 48-bit frame -> frame_error=0, new threshold used from the next cycle.
//  6. Drop reset mid-integration and mid-load -> all outputs 0 immediately.
//     params_ready=0 until a full frame has been committed.

Source files
------------

// File: rtl/lif_neuron_pkg.sv
// Shared helpers for the dual-leak LIF neuron: frame sizing, field offsets, saturation.
// Field offsets are measured from the LSB of the committed frame (refrac sits lowest).
package lif_neuron_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFRAC = 1'b1
    } neuron_state_t;

    function automatic int frame_w(input int num_ch, input int w_w, input int vmem_w,
                                   input int lcyc_w, input int ref_w);
        return num_ch * w_w + 3 * vmem_w + 2 * lcyc_w + ref_w;
    endfunction

    function automatic int off_lc2(input int ref_w);
        return ref_w;
    endfunction

    function automatic int off_lc1(input int lcyc_w, input int ref_w);
        return ref_w + lcyc_w;
    endfunction

    function automatic int off_thr(input int lcyc_w, input int ref_w);
        return ref_w + 2 * lcyc_w;
    endfunction

    function automatic int off_lr2(input int vmem_w, input int lcyc_w, input int ref_w);
        return ref_w + 2 * lcyc_w + vmem_w;
    endfunction

    function automatic int off_lr1(input int vmem_w, input int lcyc_w, input int ref_w);
        return ref_w + 2 * lcyc_w + 2 * vmem_w;
    endfunction

    function automatic int off_w(input int vmem_w, input int lcyc_w, input int ref_w);
        return ref_w + 2 * lcyc_w + 3 * vmem_w;
    endfunction

    function automatic int clamp_int(input int v, input int hi);
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/lif_param_loader.sv
// Serial config loader: shadow shift register committed atomically on the load_mode falling edge.
// Latency: new set visible the cycle after the commit edge; enable=0 freezes everything.
// No backpressure: one bit accepted per enabled load_mode cycle, extra bits flag a frame error.
module lif_param_loader #(
    parameter int FRAME_W = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load_mode,
    input  logic               serial_data,
    output logic [FRAME_W-1:0] active_params,
    output logic               params_ready,
    output logic               frame_error
);

    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [FRAME_W-1:0] shadow;
    logic [CNT_W-1:0]   bit_cnt;
    logic               load_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow        <= '0;
            bit_cnt       <= '0;
            load_q        <= 1'b0;
            active_params <= '0;
            params_ready  <= 1'b0;
            frame_error   <= 1'b0;
        end else if (enable) begin
            load_q <= load_mode;
            if (load_mode) begin
                shadow <= {shadow[FRAME_W-2:0], serial_data};
                if (bit_cnt != CNT_SAT)
                    bit_cnt <= bit_cnt + 1'b1;
            end else if (load_q) begin
                // Only an exact-length frame replaces the running set.
                if (bit_cnt == CNT_FULL) begin
                    active_params <= shadow;
                    params_ready  <= 1'b1;
                    frame_error   <= 1'b0;
                end else begin
                    frame_error   <= 1'b1;
                end
                shadow  <= '0;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lif_neuron_multi_dualleak_system.sv
// Multi-channel dual-leak LIF neuron with refractory period and serially loaded parameters.
// Latency: 1 cycle inputs->spike_out/v_mem_out; enable=0 or no committed parameters freezes the neuron.
// No backpressure: inputs sampled every enabled cycle.
module lif_neuron_multi_dualleak_system
    import lif_neuron_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 6,
    parameter int W_W    = 3,
    parameter int VMEM_W = 8,
    parameter int LCYC_W = 4,
    parameter int REF_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   input_enable,
    input  logic [NUM_CH*IN_W-1:0] chan_in,
    input  logic                   load_mode,
    input  logic                   serial_data,
    output logic                   spike_out,
    output logic [VMEM_W-1:0]      v_mem_out,
    output logic                   params_ready,
    output logic                   frame_error
);

    localparam int FRAME_W  = frame_w(NUM_CH, W_W, VMEM_W, LCYC_W, REF_W);
    localparam int SUM_W    = IN_W + W_W + $clog2(NUM_CH);
    localparam int VMAX     = (1 << VMEM_W) - 1;
    localparam int OFF_LC2  = off_lc2(REF_W);
    localparam int OFF_LC1  = off_lc1(LCYC_W, REF_W);
    localparam int OFF_THR  = off_thr(LCYC_W, REF_W);
    localparam int OFF_LR2  = off_lr2(VMEM_W, LCYC_W, REF_W);
    localparam int OFF_LR1  = off_lr1(VMEM_W, LCYC_W, REF_W);
    localparam int OFF_W    = off_w(VMEM_W, LCYC_W, REF_W);

    logic [FRAME_W-1:0] active;

    lif_param_loader #(.FRAME_W(FRAME_W)) u_loader (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .load_mode     (load_mode),
        .serial_data   (serial_data),
        .active_params (active),
        .params_ready  (params_ready),
        .frame_error   (frame_error)
    );

    logic [VMEM_W-1:0] thr, lr1, lr2;
    logic [LCYC_W-1:0] lc1, lc2;
    logic [REF_W-1:0]  refrac;

    assign refrac = active[0 +: REF_W];
    assign lc2    = active[OFF_LC2 +: LCYC_W];
    assign lc1    = active[OFF_LC1 +: LCYC_W];
    assign thr    = active[OFF_THR +: VMEM_W];
    assign lr2    = active[OFF_LR2 +: VMEM_W];
    assign lr1    = active[OFF_LR1 +: VMEM_W];

    neuron_state_t     state_q, state_d;
    logic [VMEM_W-1:0] v_mem, v_d, v_next;
    logic [LCYC_W-1:0] leak_cnt, lcnt_d, lcnt_eff, period;
    logic [REF_W-1:0]  ref_cnt, ref_d;
    logic              spike_q, spike_d;
    logic              fast, fast_q, fast_d, leak_hit;
    logic [VMEM_W-1:0] rate, leak;
    logic [SUM_W-1:0]  sum;

    always_comb begin
        sum = '0;
        if (input_enable) begin
            for (int i = 0; i < NUM_CH; i++)
                sum = sum + SUM_W'(chan_in[i*IN_W +: IN_W]) * SUM_W'(active[OFF_W + i*W_W +: W_W]);
        end
    end

    // Regime is chosen from the pre-update potential; a regime switch restarts the leak period.
    assign fast     = (v_mem >= (thr >> 1));
    assign period   = fast ? lc1 : lc2;
    assign rate     = fast ? lr1 : lr2;
    assign lcnt_eff = (fast != fast_q) ? '0 : leak_cnt;
    assign leak_hit = (period == '0) ? 1'b1 : (lcnt_eff >= period - 1'b1);
    assign leak     = leak_hit ? rate : '0;
    assign v_next   = VMEM_W'(clamp_int(int'(v_mem) + int'(sum) - int'(leak), VMAX));

    always_comb begin
        state_d = state_q;
        ref_d   = ref_cnt;
        v_d     = v_mem;
        spike_d = 1'b0;
        lcnt_d  = leak_cnt;
        fast_d  = fast;
        case (state_q)
            ST_REFRAC: begin
                v_d    = '0;
                lcnt_d = '0;
                ref_d  = ref_cnt - 1'b1;
                if (ref_cnt == REF_W'(1))
                    state_d = ST_IDLE;
            end
            default: begin
                lcnt_d = leak_hit ? '0 : lcnt_eff + 1'b1;
                if (thr != '0 && v_next >= thr) begin
                    spike_d = 1'b1;
                    v_d     = '0;
                    ref_d   = refrac;
                    if (refrac != '0)
                        state_d = ST_REFRAC;
                end else begin
                    v_d = v_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            v_mem    <= '0;
            leak_cnt <= '0;
            ref_cnt  <= '0;
            spike_q  <= 1'b0;
            fast_q   <= 1'b0;
        end else if (enable && params_ready) begin
            state_q  <= state_d;
            v_mem    <= v_d;
            leak_cnt <= lcnt_d;
            ref_cnt  <= ref_d;
            spike_q  <= spike_d;
            fast_q   <= fast_d;
        end
    end

    assign spike_out = spike_q;
    assign v_mem_out = v_mem;

endmodule

// File: tb/tb_lif_neuron_multi_dualleak_system.sv
// Bench for the dual-leak LIF neuron: directed scenarios plus randomized traffic against a behavioural model.
module tb_lif_neuron_multi_dualleak_system;

    localparam int NUM_CH = 4, IN_W = 6, W_W = 3, VMEM_W = 8, LCYC_W = 4, REF_W = 4;
    localparam int FRAME_W = 48;

    logic clk = 1'b0;
    logic reset = 1'b0, enable = 1'b0, input_enable = 1'b0, load_mode = 1'b0, serial_data = 1'b0;
    logic [NUM_CH*IN_W-1:0] chan_in = '0;
    logic spike_out, params_ready, frame_error;
    logic [VMEM_W-1:0] v_mem_out;

    lif_neuron_multi_dualleak_system dut (
        .clk(clk), .reset(reset), .enable(enable), .input_enable(input_enable),
        .chan_in(chan_in), .load_mode(load_mode), .serial_data(serial_data),
        .spike_out(spike_out), .v_mem_out(v_mem_out),
        .params_ready(params_ready), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    // reference model state
    int m_v, m_lcnt, m_ref, m_spike, m_ready, m_err, m_prev_fast, m_load_prev;
    int m_w[NUM_CH];
    int m_lr1, m_lr2, m_thr, m_lc1, m_lc2, m_rf;
    int chan[NUM_CH];
    bit m_bits[$];
    bit frame_q[$];

    task automatic model_reset();
        m_v = 0; m_lcnt = 0; m_ref = 0; m_spike = 0; m_ready = 0; m_err = 0;
        m_prev_fast = 0; m_load_prev = 0;
        for (int i = 0; i < NUM_CH; i++) m_w[i] = 0;
        m_lr1 = 0; m_lr2 = 0; m_thr = 0; m_lc1 = 0; m_lc2 = 0; m_rf = 0;
        m_bits.delete();
    endtask

    task automatic take(input int width, output int val);
        val = 0;
        for (int b = 0; b < width; b++) val = (val << 1) | int'(m_bits.pop_front());
    endtask

    task automatic model_step();
        int s, fast, period, rate, hit, vn;
        if (!enable) return;
        if (m_ready != 0) begin
            if (m_ref > 0) begin
                m_ref--; m_v = 0; m_spike = 0; m_lcnt = 0;
                m_prev_fast = (0 >= m_thr / 2) ? 1 : 0;
            end else begin
                s = 0;
                if (input_enable) for (int i = 0; i < NUM_CH; i++) s += chan[i] * m_w[i];
                fast   = (m_v >= m_thr / 2) ? 1 : 0;
                period = fast ? m_lc1 : m_lc2;
                if (period == 0) period = 1;
                rate   = fast ? m_lr1 : m_lr2;
                if (fast != m_prev_fast) m_lcnt = 0;
                m_prev_fast = fast;
                hit = (m_lcnt >= period - 1) ? 1 : 0;
                vn = m_v + s - (hit ? rate : 0);
                if (vn < 0) vn = 0;
                if (vn > 255) vn = 255;
                m_lcnt = hit ? 0 : m_lcnt + 1;
                if (m_thr != 0 && vn >= m_thr) begin
                    m_spike = 1; m_v = 0; m_ref = m_rf;
                end else begin
                    m_spike = 0; m_v = vn;
                end
            end
        end
        if (load_mode) begin
            if (m_bits.size() < FRAME_W + 1) m_bits.push_back(serial_data);
        end else if (m_load_prev != 0) begin
            if (m_bits.size() == FRAME_W) begin
                for (int i = NUM_CH - 1; i >= 0; i--) take(W_W, m_w[i]);
                take(VMEM_W, m_lr1); take(VMEM_W, m_lr2); take(VMEM_W, m_thr);
                take(LCYC_W, m_lc1); take(LCYC_W, m_lc2); take(REF_W, m_rf);
                m_ready = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
            m_bits.delete();
        end
        m_load_prev = load_mode ? 1 : 0;
    endtask

    task automatic apply_chan();
        for (int i = 0; i < NUM_CH; i++) chan_in[i*IN_W +: IN_W] = IN_W'(chan[i]);
    endtask

    task automatic set_chan(input int c0, input int c1, input int c2, input int c3);
        chan[0] = c0; chan[1] = c1; chan[2] = c2; chan[3] = c3;
        apply_chan();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic push_field(input int val, input int width);
        for (int b = width - 1; b >= 0; b--) frame_q.push_back(bit'((val >> b) & 1));
    endtask

    task automatic make_frame(input int w0, input int w1, input int w2, input int w3,
                              input int lr1, input int lr2, input int thr,
                              input int lc1, input int lc2, input int rf);
        frame_q.delete();
        push_field(w3, W_W); push_field(w2, W_W); push_field(w1, W_W); push_field(w0, W_W);
        push_field(lr1, VMEM_W); push_field(lr2, VMEM_W); push_field(thr, VMEM_W);
        push_field(lc1, LCYC_W); push_field(lc2, LCYC_W); push_field(rf, REF_W);
    endtask

    task automatic send_frame(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            load_mode = 1'b1;
            serial_data = (i < frame_q.size()) ? frame_q[i] : 1'($urandom);
            tick();
        end
        load_mode = 1'b0;
        tick();
    endtask

    logic [10:0] obs, expv;
    assign obs = {spike_out, v_mem_out, params_ready, frame_error};
    always_comb expv = {1'(m_spike), 8'(m_v), 1'(m_ready), 1'(m_err)};

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
        nvec++;
        if (obs !== 11'd0) begin
            nerr++;
            $display("FAIL reset_state: got %h want 000", obs);
        end
        tick();
        nvec++;
        if (params_ready !== 1'b0 || obs !== expv) begin
            nerr++;
            $display("FAIL reset_idle: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_periodic_fire();
        input_enable = 1'b1;
        set_chan(5, 5, 5, 5);
        make_frame(1, 1, 1, 1, 0, 0, 20, 0, 0, 2);
        send_frame(FRAME_W);
        nvec++;
        if (params_ready !== 1'b1 || obs !== expv) begin
            nerr++;
            $display("FAIL commit_ready: got %h want %h", obs, expv);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            nvec++;
            if (spike_out !== ((k % 3) == 1) || v_mem_out !== 8'd0 || obs !== expv) begin
                nerr++;
                $display("FAIL periodic_fire k=%0d: got spike=%0d v=%0d want spike=%0d v=0 (model %h)",
                         k, spike_out, v_mem_out, (k % 3) == 1, expv);
            end
        end
    endtask

    task automatic test_leak_regimes();
        input_enable = 1'b0;
        make_frame(1, 1, 1, 1, 5, 3, 200, 3, 4, 1);
        send_frame(FRAME_W);
        input_enable = 1'b1;
        set_chan(10, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            nvec++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL leak_regimes k=%0d: got %h want %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_floor_clamp();
        do_reset();
        input_enable = 1'b0;
        set_chan(5, 0, 0, 0);
        make_frame(1, 1, 1, 1, 0, 0, 200, 0, 0, 0);
        send_frame(FRAME_W);
        input_enable = 1'b1;
        tick();
        input_enable = 1'b0;
        nvec++;
        if (v_mem_out !== 8'd5 || obs !== expv) begin
            nerr++;
            $display("FAIL floor_setup: got v=%0d want 5 (model %h)", v_mem_out, expv);
        end
        make_frame(1, 1, 1, 1, 0, 8, 200, 0, 1, 0);
        send_frame(FRAME_W);
        nvec++;
        if (v_mem_out !== 8'd5) begin
            nerr++;
            $display("FAIL floor_old_params: got v=%0d want 5", v_mem_out);
        end
        tick();
        nvec++;
        if (v_mem_out !== 8'd0 || obs !== expv) begin
            nerr++;
            $display("FAIL floor_clamp: got v=%0d want 0 (model %h)", v_mem_out, expv);
        end
    endtask

    task automatic test_saturation();
        input_enable = 1'b1;
        set_chan(63, 63, 63, 63);
        make_frame(7, 7, 7, 7, 0, 0, 0, 0, 0, 0);
        send_frame(FRAME_W);
        for (int k = 0; k < 4; k++) begin
            tick();
            nvec++;
            if (v_mem_out !== 8'd255 || spike_out !== 1'b0 || obs !== expv) begin
                nerr++;
                $display("FAIL saturation k=%0d: got spike=%0d v=%0d want spike=0 v=255", k, spike_out, v_mem_out);
            end
        end
    endtask

    task automatic test_frame_error();
        do_reset();
        input_enable = 1'b0;
        set_chan(10, 0, 0, 0);
        make_frame(1, 1, 1, 1, 0, 0, 200, 0, 0, 0);
        send_frame(FRAME_W);
        input_enable = 1'b1;
        repeat (5) tick();
        input_enable = 1'b0;
        make_frame(1, 1, 1, 1, 0, 0, 40, 0, 0, 0);
        send_frame(FRAME_W - 1);
        nvec++;
        if (frame_error !== 1'b1 || params_ready !== 1'b1 || v_mem_out !== 8'd50 || obs !== expv) begin
            nerr++;
            $display("FAIL short_frame: got err=%0d rdy=%0d v=%0d want err=1 rdy=1 v=50", frame_error, params_ready, v_mem_out);
        end
        tick();
        nvec++;
        if (spike_out !== 1'b0 || v_mem_out !== 8'd50) begin
            nerr++;
            $display("FAIL short_frame_old_thr: got spike=%0d v=%0d want spike=0 v=50", spike_out, v_mem_out);
        end
        send_frame(FRAME_W + 1);
        nvec++;
        if (frame_error !== 1'b1 || obs !== expv) begin
            nerr++;
            $display("FAIL long_frame: got err=%0d want 1", frame_error);
        end
        send_frame(FRAME_W);
        nvec++;
        if (frame_error !== 1'b0 || spike_out !== 1'b0 || v_mem_out !== 8'd50) begin
            nerr++;
            $display("FAIL good_frame_commit: got err=%0d spike=%0d v=%0d want err=0 spike=0 v=50", frame_error, spike_out, v_mem_out);
        end
        tick();
        nvec++;
        if (spike_out !== 1'b1 || v_mem_out !== 8'd0 || obs !== expv) begin
            nerr++;
            $display("FAIL new_thr_fire: got spike=%0d v=%0d want spike=1 v=0", spike_out, v_mem_out);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            enable = 1'b1;
            make_frame($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 255),
                       $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
            send_frame(FRAME_W);
            for (int k = 0; k < 40; k++) begin
                enable = ($urandom_range(0, 9) != 0);
                input_enable = 1'($urandom);
                set_chan($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
                tick();
                nvec++;
                if (obs !== expv) begin
                    nerr++;
                    $display("FAIL random r=%0d k=%0d: got %h want %h", r, k, obs, expv);
                end
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midway();
        input_enable = 1'b1;
        set_chan(3, 2, 1, 0);
        make_frame(2, 2, 2, 2, 1, 1, 250, 2, 2, 0);
        send_frame(FRAME_W);
        repeat (3) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (obs !== 11'd0) begin
            nerr++;
            $display("FAIL reset_mid_integration: got %h want 000", obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            load_mode = 1'b1;
            serial_data = frame_q[i];
            tick();
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (obs !== 11'd0) begin
            nerr++;
            $display("FAIL reset_mid_load: got %h want 000", obs);
        end
        load_mode = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) tick();
        nvec++;
        if (params_ready !== 1'b0 || obs !== expv) begin
            nerr++;
            $display("FAIL ready_after_reset: got rdy=%0d want 0", params_ready);
        end
        send_frame(FRAME_W);
        nvec++;
        if (params_ready !== 1'b1 || obs !== expv) begin
            nerr++;
            $display("FAIL ready_after_frame: got rdy=%0d want 1", params_ready);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NUM_CH; i++) chan[i] = 0;
        test_reset();
        test_periodic_fire();
        test_leak_regimes();
        test_floor_clamp();
        test_saturation();
        test_frame_error();
        test_random();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
